// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a small byte FIFO; frames go out back-to-back.
// Optional UART_TX_PARITY_EN adds an even-parity bit (11-bit frame).
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy,
  output logic       full,
  output logic       empty
);

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_W = 11;
`else
  localparam int unsigned FRAME_W = 10;
`endif
  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BIT_W  = 4;

  typedef enum logic [0:0] {S_IDLE, S_TXS} state_t;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic                 r_full, r_empty;
  logic [FRAME_W-1:0]   r_shift, w_frame;
  logic [BAUD_W-1:0]    r_baud_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_tx, r_done_p, r_tx_done, r_busy;
  logic                 w_push, w_load, w_shift, w_done;
  logic [7:0]           w_rd_data;

  assign w_push    = trmt && !r_full;
  assign w_rd_data = r_mem[r_rd_ptr];
  assign w_shift   = (r_state == S_TXS) && (r_baud_cnt == BAUD_W'(BAUD_DIV - 1));

`ifdef UART_TX_PARITY_EN
  assign w_frame = {1'b1, ^w_rd_data, w_rd_data, 1'b0};
`else
  assign w_frame = {1'b1, w_rd_data, 1'b0};
`endif

  // Next state; the last shift of a frame may reload immediately for zero gap
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) begin
          w_load      = 1'b1;
          w_state_nxt = S_TXS;
        end
      end
      S_TXS: begin
        if (w_shift && (r_bit_cnt == BIT_W'(FRAME_W - 1))) begin
          w_done = 1'b1;
          if (!r_empty) w_load = 1'b1;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_load)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_load) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // TX and tx_done sit one flop behind the shifter so they stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '1;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= 1'b1;
      r_done_p   <= 1'b0;
      r_tx_done  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_TXS);
      if (w_load)       r_shift <= w_frame;
      else if (w_shift) r_shift <= {1'b1, r_shift[FRAME_W-1:1]};
      if (w_load || w_shift)      r_baud_cnt <= '0;
      else if (r_state == S_TXS)  r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
      if (w_load)       r_bit_cnt <= '0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      r_tx      <= r_shift[0];
      r_done_p  <= w_done;
      r_tx_done <= r_done_p;
    end
  end

  assign TX      = r_tx;
  assign tx_done = r_tx_done;
  assign busy    = r_busy;
  assign full    = r_full;
  assign empty   = r_empty;

endmodule
